// File: rtl/prng_mask_pool_pkg.sv
// Shared constants, state encoding and LFSR step function for the mask randomness pool.
package prng_mask_pool_pkg;

    localparam int LFSR_W = 32;
    localparam int TAP_A  = 31;
    localparam int TAP_B  = 28;
    localparam int TAP_C  = 0;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED0 = 32'hE4106D0C;
    localparam logic [LFSR_W-1:0] DEFAULT_SEEDN = 32'h9973CD2D;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_SEED   = 2'd2
    } state_e;

    // chain_bit couples each lane to the MSB of the lane below it (0 for lane 0).
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                    input logic              chain_bit);
        return {s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ chain_bit, s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/prng_mask_pool_if.sv
// Seed and random-word handshakes plus status of the mask pool.
interface prng_mask_pool_if
    import prng_mask_pool_pkg::*;
#(
    parameter int OUTLENGTH = 64
);
    logic                 seed_valid;
    logic [LFSR_W-1:0]    seed_data;
    logic                 seed_ready;
    logic                 rnd_valid;
    logic                 rnd_ready;
    logic [OUTLENGTH-1:0] rnd_data;
    logic                 busy;
    logic                 seed_err;

    modport slave (
        input  seed_valid, seed_data, rnd_ready,
        output seed_ready, rnd_valid, rnd_data, busy, seed_err
    );

    modport master (
        output seed_valid, seed_data, rnd_ready,
        input  seed_ready, rnd_valid, rnd_data, busy, seed_err
    );
endinterface

// File: rtl/prng_mask_pool_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
module prng_mask_pool_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB tells full (MSBs differ) from empty (MSBs equal).
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/prng_mask_pool.sv
// Multi-lane chained LFSR pool with seed handshake, warm-up phase and buffered output.
module prng_mask_pool
    import prng_mask_pool_pkg::*;
#(
    parameter int OUTLENGTH  = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int WARMUP     = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    prng_mask_pool_if.slave bus
);
    localparam int NUM_LANES = (OUTLENGTH + LFSR_W - 1) / LFSR_W;
    localparam int CNT_W     = $clog2(WARMUP + 1);
    localparam int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        err_q, err_d;
    logic [LFSR_W-1:0]           lane_q    [NUM_LANES];
    logic [LFSR_W-1:0]           lane_d    [NUM_LANES];
    logic [LFSR_W-1:0]           lane_step [NUM_LANES];
    logic [NUM_LANES*LFSR_W-1:0] lanes_flat;
    logic                        seed_fire;
    logic                        seed_zero;
    logic [LFSR_W-1:0]           seed_word;
    logic                        fifo_push;
    logic                        fifo_flush;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [OUTLENGTH-1:0]        fifo_rdata;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_step[i] = lfsr_step(lane_q[i],
                                     (i == 0) ? 1'b0 : lane_q[(i == 0) ? 0 : i - 1][LFSR_W-1]);
            lanes_flat[i*LFSR_W +: LFSR_W] = lane_q[i];
        end
    end

    // idx_q is 0 outside SEED, so the first word of a run-time reseed lands in lane 0.
    assign seed_fire = bus.seed_valid && (state_q != ST_WARMUP);
    assign seed_zero = (bus.seed_data == '0);
    assign seed_word = !seed_zero ? bus.seed_data :
                       (idx_q == '0) ? DEFAULT_SEED0 : DEFAULT_SEEDN;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        err_d      = err_q;
        lane_d     = lane_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        unique case (state_q)
            ST_WARMUP: begin
                lane_d = lane_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WARMUP - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN, ST_SEED: begin
                if (seed_fire) begin
                    lane_d[idx_q] = seed_word;
                    err_d         = err_q | seed_zero;
                    fifo_flush    = 1'b1;
                    if (idx_q == IDX_W'(NUM_LANES - 1)) begin
                        state_d = ST_WARMUP;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_SEED;
                        idx_d   = idx_q + 1'b1;
                    end
                end else if (state_q == ST_RUN) begin
                    // Lanes free-run; words produced while the FIFO is full are dropped.
                    lane_d    = lane_step;
                    fifo_push = !fifo_full;
                end
            end
            default: begin
                state_d = ST_WARMUP;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_WARMUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_q[i] <= (i == 0) ? DEFAULT_SEED0 : DEFAULT_SEEDN;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            lane_q  <= lane_d;
        end
    end

    prng_mask_pool_fifo #(
        .WIDTH (OUTLENGTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .data_i  (lanes_flat[OUTLENGTH-1:0]),
        .pop_i   (bus.rnd_ready),
        .data_o  (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign bus.rnd_valid  = !fifo_empty;
    assign bus.rnd_data   = fifo_rdata;
    assign bus.seed_ready = (state_q != ST_WARMUP);
    assign bus.busy       = (state_q != ST_RUN);
    assign bus.seed_err   = err_q;

endmodule

// File: tb/tb_prng_mask_pool.sv
// Directed and randomised checks of the mask pool with a 2-lane, 4-deep, 1-step warm-up build.
module tb_prng_mask_pool;
    localparam int          OUTLENGTH  = 64;
    localparam int          FIFO_DEPTH = 4;
    localparam int          WARMUP     = 1;
    localparam logic [31:0] D0         = 32'hE4106D0C;
    localparam logic [31:0] DN         = 32'h9973CD2D;
    localparam logic [63:0] W1         = 64'h4CB9E696_F2083686;
    localparam logic [63:0] W2         = 64'hA65CF34B_79041B43;
    localparam logic [63:0] W3         = 64'h532E79A5_3C820DA1;
    localparam logic [63:0] W4         = 64'h29973CD2_1E4106D0;
    localparam logic [63:0] W5         = 64'h14CB9E69_8F208368;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    prng_mask_pool_if #(.OUTLENGTH(OUTLENGTH)) bus ();

    prng_mask_pool #(
        .OUTLENGTH  (OUTLENGTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .WARMUP     (WARMUP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs [7];

    // Reference model state for the randomised run
    int          m_state;
    int          m_cnt;
    int          m_idx;
    logic [31:0] m_l0, m_l1;
    logic        m_err;
    logic [63:0] mq [$];
    logic        sv, rr;
    logic [31:0] sd;

    function automatic logic [31:0] tb_step(input logic [31:0] s, input logic cb);
        logic fb;
        fb = s[31] ^ s[28] ^ s[0] ^ cb;
        return {fb, s[31:1]};
    endfunction

    function automatic logic [63:0] word_at(input int n);
        logic [31:0] a, b, na, nb;
        a = D0;
        b = DN;
        for (int k = 0; k < n; k++) begin
            na = tb_step(a, 1'b0);
            nb = tb_step(b, a[31]);
            a  = na;
            b  = nb;
        end
        return {b, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic ready);
        bus.rnd_ready = ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        bus.seed_valid = 1'b0;
        bus.seed_data  = '0;
        bus.rnd_ready  = 1'b0;
        repeat (2) cyc(1'b0);
        rst_n = 1'b1;
    endtask

    task automatic model_edge();
        logic [31:0] n0, n1, sw;
        logic        fire, pop_ok, full;
        fire   = sv && (m_state != 0);
        pop_ok = rr && (mq.size() > 0);
        full   = (mq.size() == FIFO_DEPTH);
        n0     = tb_step(m_l0, 1'b0);
        n1     = tb_step(m_l1, m_l0[31]);
        sw     = (sd != 0) ? sd : ((m_idx == 0) ? D0 : DN);
        if (m_state == 0) begin
            m_l0 = n0;
            m_l1 = n1;
            if (m_cnt == WARMUP - 1) begin
                m_state = 1;
                m_cnt   = 0;
            end else begin
                m_cnt++;
            end
        end else if (fire) begin
            if (m_idx == 0) m_l0 = sw;
            else            m_l1 = sw;
            if (sd == 0) m_err = 1'b1;
            mq.delete();
            if (m_idx == 1) begin
                m_state = 0;
                m_idx   = 0;
                m_cnt   = 0;
            end else begin
                m_state = 2;
                m_idx   = 1;
            end
        end else if (m_state == 1) begin
            if (pop_ok) mq.delete(0);
            if (!full) mq.push_back({m_l1, m_l0});
            m_l0 = n0;
            m_l1 = n1;
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 64'h0};
        vecs[1] = '{1'b1, 1'b1, W1};
        vecs[2] = '{1'b1, 1'b1, W2};
        vecs[3] = '{1'b0, 1'b1, W2};
        vecs[4] = '{1'b1, 1'b1, W3};
        vecs[5] = '{1'b1, 1'b1, W4};
        vecs[6] = '{1'b1, 1'b1, W5};

        rst_n          = 1'b0;
        bus.seed_valid = 1'b0;
        bus.seed_data  = '0;
        bus.rnd_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", bus.rnd_valid, 0);
        check("rst_data", bus.rnd_data, 0);
        check("rst_seed_ready", bus.seed_ready, 0);
        check("rst_busy", bus.busy, 1);
        check("rst_seed_err", bus.seed_err, 0);
        rst_n = 1'b1;

        // Post-reset stream with a single stall
        for (int i = 0; i < 7; i++) begin
            cyc(vecs[i].ready);
            check($sformatf("vec%0d_valid", i), bus.rnd_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_data", i), bus.rnd_data, vecs[i].exp_data);
        end

        // Backpressure: FIFO fills with W1..W4, later words dropped
        apply_reset();
        cyc(1'b0);
        check("t2_busy_after_warmup", bus.busy, 0);
        check("t2_empty_after_warmup", bus.rnd_valid, 0);
        for (int e = 1; e <= 9; e++) begin
            cyc(1'b0);
            if (e >= 4) begin
                check($sformatf("t2_hold_e%0d", e), bus.rnd_data, W1);
                check($sformatf("t2_valid_e%0d", e), bus.rnd_valid, 1);
            end
        end
        cyc(1'b1);
        check("t2_pop_head", bus.rnd_data, W2);
        check("t2_pop_valid", bus.rnd_valid, 1);
        cyc(1'b0);
        cyc(1'b1);
        check("t2_head_w3", bus.rnd_data, W3);
        cyc(1'b1);
        check("t2_head_w4", bus.rnd_data, W4);
        cyc(1'b1);
        check("t2_head_refill", bus.rnd_data, word_at(11));

        // Run-time reseed with the defaults
        bus.seed_valid = 1'b1;
        bus.seed_data  = D0;
        check("t3_seed_ready_run", bus.seed_ready, 1);
        cyc(1'b0);
        check("t3_flush", bus.rnd_valid, 0);
        check("t3_busy_seed", bus.busy, 1);
        check("t3_seed_ready_seed", bus.seed_ready, 1);
        bus.seed_data = DN;
        cyc(1'b0);
        check("t3_busy_warm", bus.busy, 1);
        check("t3_seed_ready_warm", bus.seed_ready, 0);
        check("t3_valid_warm", bus.rnd_valid, 0);
        bus.seed_valid = 1'b0;
        cyc(1'b0);
        check("t3_busy_run", bus.busy, 0);
        check("t3_valid_run", bus.rnd_valid, 0);
        cyc(1'b0);
        check("t3_w1", bus.rnd_data, W1);
        cyc(1'b1);
        check("t3_w2", bus.rnd_data, W2);
        cyc(1'b1);
        check("t3_w3", bus.rnd_data, W3);
        check("t3_seed_err", bus.seed_err, 0);

        // Zero seed word for lane 1 is replaced by its default
        bus.seed_valid = 1'b1;
        bus.seed_data  = D0;
        cyc(1'b0);
        bus.seed_data = 32'h0;
        cyc(1'b0);
        check("t4_seed_err_set", bus.seed_err, 1);
        bus.seed_valid = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        check("t4_w1", bus.rnd_data, W1);
        cyc(1'b1);
        check("t4_w2", bus.rnd_data, W2);
        repeat (5) cyc(1'b1);
        check("t4_seed_err_sticky", bus.seed_err, 1);

        // Reset in the middle of a seed transfer
        bus.seed_valid = 1'b1;
        bus.seed_data  = 32'h12345678;
        cyc(1'b0);
        check("t5_in_seed", bus.busy, 1);
        bus.seed_valid = 1'b0;
        rst_n          = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        check("t5_rst_err", bus.seed_err, 0);
        check("t5_rst_ready", bus.seed_ready, 0);
        check("t5_rst_valid", bus.rnd_valid, 0);
        check("t5_rst_data", bus.rnd_data, 0);
        rst_n = 1'b1;
        cyc(1'b1);
        check("t5_e0_valid", bus.rnd_valid, 0);
        cyc(1'b1);
        check("t5_w1", bus.rnd_data, W1);
        cyc(1'b1);
        check("t5_w2", bus.rnd_data, W2);
        cyc(1'b1);
        check("t5_w3", bus.rnd_data, W3);

        // Random ready/seed traffic against the cycle model
        apply_reset();
        m_state = 0;
        m_cnt   = 0;
        m_idx   = 0;
        m_l0    = D0;
        m_l1    = DN;
        m_err   = 1'b0;
        mq.delete();
        for (int c = 0; c < 4000; c++) begin
            sv = ($urandom_range(0, 31) == 0);
            sd = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
            rr = 1'($urandom_range(0, 1));
            bus.seed_valid = sv;
            bus.seed_data  = sd;
            bus.rnd_ready  = rr;
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check($sformatf("t6_ctrl_c%0d", c),
                  {bus.rnd_valid, bus.seed_ready, bus.busy, bus.seed_err},
                  {(mq.size() > 0), (m_state != 0), (m_state != 1), m_err});
            check($sformatf("t6_data_c%0d", c), bus.rnd_data,
                  (mq.size() > 0) ? mq[0] : 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
